// File: rtl/pmod_enc_debouncer.sv
// Two-flop synchronizer plus per-channel stability-counter debouncer for the PMOD ENC lines.
// Emits registered debounced levels and one-cycle rise/fall pulses per channel.
module pmod_enc_debouncer #(
    parameter int unsigned         N_CH          = 4,
    parameter int unsigned         STABLE_CYCLES = 50000,
    parameter int unsigned         CNT_W         = 16,
    parameter logic [N_CH-1:0]     RESET_LEVEL   = 4'b0011
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [N_CH-1:0]  r_out;
    logic [N_CH-1:0]  r_rise;
    logic [N_CH-1:0]  r_fall;
    logic [CNT_W-1:0] r_cnt [N_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= RESET_LEVEL;
            r_s2   <= RESET_LEVEL;
            r_out  <= RESET_LEVEL;
            r_rise <= '0;
            r_fall <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                // Any return to the current level discards the partial count.
                if (r_s2[i] == r_out[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_LAST) begin
                    r_out[i]  <= r_s2[i];
                    r_cnt[i]  <= '0;
                    r_rise[i] <= r_s2[i];
                    r_fall[i] <= ~r_s2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
